// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and flush controller: stage valid tracking,
// age-ordered redirect arbitration, kill masks, hold and drain.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned NUM_REDIR = 3,
  parameter logic [4*NUM_REDIR-1:0] REDIR_STAGE = {4'd2, 4'd2, 4'd3},
  parameter logic [NUM_REDIR-1:0] REDIR_SELF = 3'b010,
  parameter int unsigned PC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      finish,
  input  logic [NUM_REDIR-1:0]      redir_req,
  input  logic [NUM_REDIR*PC_W-1:0] redir_pc,
  output logic                      fetch_en_o,
  output logic [NUM_STAGES-1:0]     stage_valid_o,
  output logic [NUM_STAGES-1:0]     kill_o,
  output logic                      redirect_valid_o,
  output logic [PC_W-1:0]           redirect_pc_o,
  output logic [NUM_REDIR-1:0]      redirect_src_o,
  output logic [CNT_W-1:0]          redirect_cnt_o,
  output logic                      drained_o
);

  logic [NUM_STAGES-1:0] v;
  logic                  fetch_en;
  logic                  finish_q;
  logic [CNT_W-1:0]      cnt;
  logic                  drained;

  logic [NUM_REDIR-1:0]  qual;
  logic [NUM_REDIR-1:0]  win_oh;
  logic [3:0]            win_stage;
  logic                  win_any;
  logic                  win_self;
  logic [PC_W-1:0]       win_pc;
  logic [NUM_STAGES-1:0] kill;

  function automatic logic stage_hit(
    input logic [NUM_STAGES-1:0] vv,
    input logic [3:0]            s
  );
    stage_hit = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (4'(i) == s) stage_hit = vv[i];
  endfunction

  always_comb begin
    qual = '0;
    for (int r = 0; r < NUM_REDIR; r++)
      qual[r] = redir_req[r] & ~hold &
                stage_hit(v, REDIR_STAGE[4*r +: 4]);
  end

  // Oldest stage wins; strict compare keeps the lowest index on ties.
  always_comb begin
    win_any   = 1'b0;
    win_oh    = '0;
    win_stage = '0;
    win_self  = 1'b0;
    win_pc    = '0;
    for (int r = 0; r < NUM_REDIR; r++) begin
      if (qual[r] &&
          (!win_any || REDIR_STAGE[4*r +: 4] > win_stage)) begin
        win_any   = 1'b1;
        win_oh    = '0;
        win_oh[r] = 1'b1;
        win_stage = REDIR_STAGE[4*r +: 4];
        win_self  = REDIR_SELF[r];
        win_pc    = redir_pc[PC_W*r +: PC_W];
      end
    end
  end

  always_comb begin
    kill = '0;
    if (win_any)
      for (int i = 0; i < NUM_STAGES; i++)
        kill[i] = (4'(i) < win_stage) |
                  (win_self & (4'(i) == win_stage));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish_q <= 1'b0;
      drained  <= 1'b0;
    end else begin
      finish_q <= finish_q | finish;
      drained  <= finish_q & ~|v;
    end
  end

  // The fetch issued alongside a redirect uses the new PC, so v[0] is never killed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v        <= '0;
      fetch_en <= 1'b0;
    end else if (!hold) begin
      v        <= {v[NUM_STAGES-2:0] & ~kill[NUM_STAGES-2:0], fetch_en};
      fetch_en <= ~finish_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!hold && win_any && !(&cnt))
      cnt <= cnt + CNT_W'(1);
  end

  assign fetch_en_o       = fetch_en;
  assign stage_valid_o    = v;
  assign kill_o           = kill;
  assign redirect_valid_o = win_any;
  assign redirect_pc_o    = win_pc;
  assign redirect_src_o   = win_oh;
  assign redirect_cnt_o   = cnt;
  assign drained_o        = drained;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random
// redirect/hold traffic against a stage-list reference model.
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int NR = 3;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset, hold, finish;
  logic [NR-1:0]    redir_req;
  logic [NR*PW-1:0] redir_pc;

  logic          fe, rv, dr;
  logic [NS-1:0] sv, kl;
  logic [PW-1:0] rpc;
  logic [NR-1:0] rsrc;
  logic [15:0]   cnt;

  logic          fe_b, rv_b, dr_b;
  logic [NS-1:0] sv_b, kl_b;
  logic [PW-1:0] rpc_b;
  logic [NR-1:0] rsrc_b;
  logic [1:0]    cnt_b;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .hold(hold), .finish(finish),
    .redir_req(redir_req), .redir_pc(redir_pc),
    .fetch_en_o(fe), .stage_valid_o(sv), .kill_o(kl),
    .redirect_valid_o(rv), .redirect_pc_o(rpc),
    .redirect_src_o(rsrc), .redirect_cnt_o(cnt),
    .drained_o(dr)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .hold(hold), .finish(finish),
    .redir_req(redir_req), .redir_pc(redir_pc),
    .fetch_en_o(fe_b), .stage_valid_o(sv_b), .kill_o(kl_b),
    .redirect_valid_o(rv_b), .redirect_pc_o(rpc_b),
    .redirect_src_o(rsrc_b), .redirect_cnt_o(cnt_b),
    .drained_o(dr_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // r0 = EX branch, r1 = RR load-use (self-kill), r2 = RR jal
  function automatic int stage_of(int r);
    return (r == 0) ? 3 : 2;
  endfunction

  function automatic int self_of(int r);
    return (r == 1) ? 1 : 0;
  endfunction

  int mv[NS];
  int mfe, mfq, mdr, mcnt, mcnt2;
  logic [PW-1:0] pcv[NR];
  int best, bs, ekill, vmask;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mv[i] = 0;
    mfe = 0; mfq = 0; mdr = 0; mcnt = 0; mcnt2 = 0;
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic h,
                       input logic f);
    redir_req = req;
    hold = h;
    finish = f;
    for (int r = 0; r < NR; r++) pcv[r] = $urandom;
    redir_pc = {pcv[2], pcv[1], pcv[0]};
  endtask

  task automatic check();
    @(negedge clk);
    best = -1;
    bs = -1;
    if (!hold)
      for (int r = 0; r < NR; r++)
        if (redir_req[r] && mv[stage_of(r)] != 0 && stage_of(r) > bs) begin
          best = r;
          bs = stage_of(r);
        end
    ekill = (best < 0) ? 0 : (((1 << bs) - 1) | (self_of(best) << bs));
    vmask = 0;
    for (int i = 0; i < NS; i++) vmask = vmask | (mv[i] << i);
    chk("fetch_en", fe, mfe);
    chk("stage_valid", sv, vmask);
    chk("kill", kl, ekill);
    chk("redir_valid", rv, best >= 0);
    chk("redir_pc", rpc, (best < 0) ? '0 : pcv[best]);
    chk("redir_src", rsrc, (best < 0) ? 0 : (1 << best));
    chk("redir_cnt", cnt, mcnt);
    chk("drained", dr, mdr);
    chk("b_fetch_en", fe_b, mfe);
    chk("b_stage_valid", sv_b, vmask);
    chk("b_kill", kl_b, ekill);
    chk("b_redir_valid", rv_b, best >= 0);
    chk("b_redir_pc", rpc_b, (best < 0) ? '0 : pcv[best]);
    chk("b_redir_src", rsrc_b, (best < 0) ? 0 : (1 << best));
    chk("b_redir_cnt", cnt_b, mcnt2);
    chk("b_drained", dr_b, mdr);
  endtask

  task automatic adv();
    int ndr;
    @(posedge clk);
    if (!reset) begin
      ndr = (mfq != 0 && vmask == 0) ? 1 : 0;
      if (!hold) begin
        for (int i = NS - 1; i > 0; i--)
          mv[i] = (mv[i-1] != 0 && ekill[i-1] == 1'b0) ? 1 : 0;
        mv[0] = mfe;
        mfe = (mfq != 0) ? 0 : 1;
        if (best >= 0) begin
          if (mcnt < 65535) mcnt++;
          if (mcnt2 < 3) mcnt2++;
        end
      end
      mfq = (mfq != 0 || finish) ? 1 : 0;
      mdr = ndr;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive('0, 1'b0, 1'b0);
      check();
      adv();
    end
  endtask

  initial begin : main
    int fell, dk, seen;
    reset = 1'b1;
    hold = 1'b0;
    finish = 1'b0;
    redir_req = '0;
    redir_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    drive('0, 1'b0, 1'b0);
    check();
    adv();
    reset = 1'b0;

    // fill, with a squashed EX request while v[3] is empty
    for (int c = 0; c < 7; c++) begin
      drive((c == 2) ? 3'b001 : 3'b000, 1'b0, 1'b0);
      check();
      if (c == 2) chk("squashed_rv", rv, 0);
      adv();
    end
    chk("fill_sv", sv, 5'b11111);
    chk("fill_cnt", cnt, 0);

    // EX branch
    drive(3'b001, 1'b0, 1'b0);
    pcv[0] = 32'h100;
    redir_pc = {pcv[2], pcv[1], pcv[0]};
    check();
    chk("ex_rv", rv, 1);
    chk("ex_pc", rpc, 32'h100);
    chk("ex_kill", kl, 5'b00111);
    adv();
    drive('0, 1'b0, 1'b0);
    check();
    chk("ex_sv", sv, 5'b10001);
    chk("ex_cnt", cnt, 1);
    adv();
    idle(4);

    // all three sources
    drive(3'b111, 1'b0, 1'b0);
    check();
    chk("all_src", rsrc, 3'b001);
    chk("all_pc", rpc, pcv[0]);
    adv();
    idle(5);

    // load-use beats jal at the same stage
    drive(3'b110, 1'b0, 1'b0);
    check();
    chk("lu_src", rsrc, 3'b010);
    chk("lu_kill", kl, 5'b00111);
    adv();
    drive('0, 1'b0, 1'b0);
    check();
    chk("lu_sv", sv, 5'b10001);
    adv();
    idle(5);

    // request under hold
    drive(3'b001, 1'b1, 1'b0);
    check();
    chk("hold_rv", rv, 0);
    chk("hold_kill", kl, 0);
    adv();
    drive('0, 1'b0, 1'b0);
    check();
    chk("hold_sv", sv, 5'b11111);
    chk("hold_cnt", cnt, 3);
    adv();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0, 1'b0);
      check();
      adv();
    end
    chk("sat_cnt", cnt_b, 2'b11);

    // finish then reset mid-drain
    idle(6);
    drive('0, 1'b0, 1'b1);
    check();
    adv();
    idle(3);
    drive('0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_fe", fe, 0);
    chk("rst_sv", sv, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_dr", dr, 0);
    chk("rst_kill", kl, 0);
    model_reset();
    check();
    adv();
    reset = 1'b0;
    idle(1);
    chk("resume_fe", fe, 1);

    // full drain
    idle(7);
    drive('0, 1'b0, 1'b1);
    check();
    adv();
    fell = -1;
    dk = -1;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      drive('0, 1'b0, 1'b0);
      check();
      if (!fe && fell < 0) fell = k;
      if (dr) begin
        seen = 1;
        dk = k;
      end
      adv();
    end
    chk("drain_done", seen, 1);
    chk("drain_fe_next", fell, 1);
    chk("drain_lat", (dk - fell) <= NS + 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and flush controller for the in-order RV32I core family. It tracks a valid bit per pipeline stage and arbitrates a configurable set of redirect sources (branch, jal, load-use refetch, …) by stage age. It generates per-stage kill masks and the single refetch PC for the fetch unit, and handles pipeline hold and end-of-program drain. It replaces the hard-coded 3-bit invalidate shift register and stage-enable chain in the core top with one generic block for any stage count and any number of redirect sources.

## Interface
Parameters:
- `NUM_STAGES`, default 5: number of pipeline stages. Stage 0 is fetch and stage `NUM_STAGES-1` is the oldest (writeback); range 2–15.
- `NUM_REDIR`, default 3: number of redirect sources; range 1–8.
- `REDIR_STAGE`, default {4'd2,4'd2,4'd3}: packed 4-bit stage index per source; source r occupies bits [4r+3:4r].
- `REDIR_SELF`, default 3'b010: bit r = 1 means source r also kills its own stage (the instruction is refetched).
- `PC_W`, default 32: PC width.
- `CNT_W`, default 16: width of the redirect event counter.

Ports:
- `clk`, in, 1: core clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `hold`, in, 1: freeze the whole pipeline (memory wait).
- `finish`, in, 1: stop fetching and drain.
- `redir_req`, in, `NUM_REDIR`: redirect request per source.
- `redir_pc`, in, `NUM_REDIR*PC_W`: target PC per source, packed like `REDIR_STAGE`.
- `fetch_en_o`, out, 1: registered permission to issue a fetch.
- `stage_valid_o`, out, `NUM_STAGES`: registered valid bit per stage.
- `kill_o`, out, `NUM_STAGES`: combinational squash mask for this cycle. The datapath gates register and memory writes of killed stages with it.
- `redirect_valid_o`, out, 1: combinational refetch strobe to fetch.
- `redirect_pc_o`, out, `PC_W`: combinational refetch PC.
- `redirect_src_o`, out, `NUM_REDIR`: one-hot winning source.
- `redirect_cnt_o`, out, `CNT_W`: saturating count of accepted redirects.
- `drained_o`, out, 1: registered; finish latched and all stages empty.

## Operation
- **Source qualification:** source r is qualified when `redir_req[r] & v[REDIR_STAGE[r]] & ~hold`. A request from an invalid (already squashed) stage is ignored.
- **Arbitration:** the winner is the qualified source with the highest stage index, because it holds the oldest instruction. Ties go to the lowest r.
- **Redirect outputs:** with no qualified source, `redirect_valid_o`, `redirect_src_o` and `kill_o` are 0, and `redirect_pc_o` is 0.
- **Kill mask:** with winner at stage s, `kill_o` covers stages 0..s-1. It also covers stage s when `REDIR_SELF[r]` is set.
- **Stage advance** (when `hold` = 0):
  - `v[0] <= fetch_en_o`. The fetch issued in a redirect cycle comes from the new PC and is valid.
  - `v[i] <= v[i-1] & ~kill_o[i-1]` for i ≥ 1.
- **Hold:** when `hold` = 1, `v`, the counter and `fetch_en_o` keep their values. `redirect_valid_o` and `kill_o` are 0.
- **Fetch enable:** `fetch_en_o <= ~finish_q`. `finish_q` is a sticky latch of `finish` and is cleared only by reset.
- **Drain:** `drained_o <= finish_q & (v == 0)`.
- **Counter:** `redirect_cnt_o` increments on every accepted redirect and saturates at all-ones.

## Timing
- **Reset values:** every output is 0 while `reset` is high and `finish_q` is 0.
- **After reset release:** `fetch_en_o` = 1 after the first clock edge. `v` then fills one stage per cycle, so the first instruction is in stage `NUM_STAGES-1` at edge `NUM_STAGES`+1.
- **Same-cycle redirect:** redirect outputs and `kill_o` are combinational, in the same cycle as `redir_req`. Their effect on `stage_valid_o` appears after the next edge.
- **`finish`:** `fetch_en_o` falls one edge after `finish` is sampled. `drained_o` rises at most `NUM_STAGES`+1 edges later, or later if `hold` stretches the drain.
- **Reset mid-operation:** reset clears `v`, `finish_q`, the counter and `drained_o` immediately and asynchronously.

## Test plan
All scenarios use the default parameters: stages IF=0, ID=1, RR=2, EX=3, LR=4; r0 = EX branch, r1 = RR load-use (self-kill), r2 = RR jal.

- **Fill:** release reset with no other inputs → `stage_valid_o` goes 00001, 00011, …, 11111; `redirect_cnt_o` = 0.
- **EX branch:** pipeline full, `redir_req` = 001, r0 PC = 0x100 → same cycle `redirect_valid_o` = 1, `redirect_pc_o` = 0x100, `kill_o` = 00111. Next cycle `stage_valid_o` = 10001 and `redirect_cnt_o` = 1.
- **Simultaneous sources:** pipeline full, `redir_req` = 111 → `redirect_src_o` = 001 with r0's PC. With `redir_req` = 110, r1 wins over r2, `kill_o` = 00111, and the next-cycle `stage_valid_o` = 10001.
- **Squashed and held requests:** r0 asserted while `v[3]` = 0 → no redirect. A request while `hold` = 1 → no redirect, `stage_valid_o` unchanged, counter unchanged.
- **Counter saturation:** with `CNT_W` = 2, apply 5 accepted redirects → `redirect_cnt_o` stays at 3.
- **Finish and reset:** pipeline full, pulse `finish` → `fetch_en_o` = 0 next cycle and `drained_o` = 1 after 6 edges. Assert `reset` mid-drain → all outputs 0 immediately; after release, fetch resumes.
